// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode constants, widths and opcode legality check
package alu_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // True for the five opcodes the ALU implements; 011, 100 and 101 are holes.
   function automatic logic alu_op_legal(input logic [2:0] op);
      logic legal;
      legal = 1'b0;
      case (op)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: legal = 1'b1;
         default:                                    legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - architectural register file, two async read ports, one sync write port
module reg_file_2r1w #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rd_addr1,
   output logic [XLEN-1:0] rd_data1,
   input  logic [AW-1:0]   rd_addr2,
   output logic [XLEN-1:0] rd_data2,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data
);

   logic [XLEN-1:0] regs [NREG];

   // Register storage: cleared on reset, x0 never written so its entry stays zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en && (wr_addr != '0)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // x0 is forced to zero on the read side as well, independent of storage contents.
   assign rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
   assign rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX operand stage: register read, writeback bypass, one-slot output buffer
module alu_operand_stage #(
   parameter int XLEN = alu_pkg::XLEN,
   parameter int NREG = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [alu_pkg::REG_AW-1:0] in_rs1,
   input  logic [alu_pkg::REG_AW-1:0] in_rs2,
   input  logic [alu_pkg::REG_AW-1:0] in_rd,
   input  logic [XLEN-1:0]           in_imm,
   input  logic                      in_use_imm,
   input  logic [2:0]                in_op,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [XLEN-1:0]           out_a,
   output logic [XLEN-1:0]           out_b,
   output logic [2:0]                out_op,
   output logic [alu_pkg::REG_AW-1:0] out_rd,
   output logic                      out_illegal,
   input  logic                      wb_en,
   input  logic [alu_pkg::REG_AW-1:0] wb_addr,
   input  logic [XLEN-1:0]           wb_data
);

   import alu_pkg::*;

   logic [XLEN-1:0] rf_a;
   logic [XLEN-1:0] rf_b;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_rs2;
   logic [XLEN-1:0] src_b;
   logic            accept;

   reg_file_2r1w #(
      .XLEN (XLEN),
      .NREG (NREG),
      .AW   (REG_AW)
   ) u_rf (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_addr1 (in_rs1),
      .rd_data1 (rf_a),
      .rd_addr2 (in_rs2),
      .rd_data2 (rf_b),
      .wr_en    (wb_en),
      .wr_addr  (wb_addr),
      .wr_data  (wb_data)
   );

   // Ready depends only on slot state and downstream ready, never on in_valid.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   // Operand selection: x0 wins over the bypass so a wb to x0 can never leak through.
   always_comb begin
      src_a   = '0;
      src_rs2 = '0;
      if (in_rs1 != '0) begin
         src_a = (wb_en && (wb_addr == in_rs1)) ? wb_data : rf_a;
      end
      if (in_rs2 != '0) begin
         src_rs2 = (wb_en && (wb_addr == in_rs2)) ? wb_data : rf_b;
      end
      src_b = in_use_imm ? in_imm : src_rs2;
   end

   // Output slot: flush beats accept, accept beats drain; fields hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_a       <= '0;
         out_b       <= '0;
         out_op      <= '0;
         out_rd      <= '0;
         out_illegal <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         out_a       <= src_a;
         out_b       <= src_b;
         out_op      <= in_op;
         out_rd      <= in_rd;
         out_illegal <= !alu_op_legal(in_op);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed self-checking bench with a behavioural reference model
module tb_alu_operand_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [4:0]  in_rd;
   logic [31:0] in_imm;
   logic        in_use_imm;
   logic [2:0]  in_op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [2:0]  out_op;
   logic [4:0]  out_rd;
   logic        out_illegal;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   int vectors;
   int miscompares;

   alu_operand_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .in_rd       (in_rd),
      .in_imm      (in_imm),
      .in_use_imm  (in_use_imm),
      .in_op       (in_op),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_op      (out_op),
      .out_rd      (out_rd),
      .out_illegal (out_illegal),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural registers plus the one instruction the stage should be holding.
   logic [31:0] m_regs [32];
   logic        m_valid;
   logic [31:0] m_a;
   logic [31:0] m_b;
   logic [2:0]  m_op;
   logic [4:0]  m_rd;
   logic        m_ill;

   function automatic logic [31:0] m_read(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (wb_en && wb_addr == r) return wb_data;
      return m_regs[r];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_valid = 1'b0;
         m_a = 32'd0; m_b = 32'd0; m_op = 3'd0; m_rd = 5'd0; m_ill = 1'b0;
      end else begin
         if (flush) begin
            m_valid = 1'b0;
         end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid = 1'b1;
            m_a   = m_read(in_rs1);
            m_b   = in_use_imm ? in_imm : m_read(in_rs2);
            m_op  = in_op;
            m_rd  = in_rd;
            m_ill = (in_op == 3'b011) || (in_op == 3'b100) || (in_op == 3'b101);
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
         if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
      end
   end

   // Every-cycle comparison against the model, half a period away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
         chk("rst_out_a", out_a, 32'd0);
      end else begin
         chk("in_ready", {31'd0, in_ready}, {31'd0, !m_valid || out_ready});
         chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
         if (m_valid) begin
            chk("out_a", out_a, m_a);
            chk("out_b", out_b, m_b);
            chk("out_op", {29'd0, out_op}, {29'd0, m_op});
            chk("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
            chk("out_illegal", {31'd0, out_illegal}, {31'd0, m_ill});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
      in_imm = 0; in_use_imm = 0; in_op = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
   endtask

   task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [2:0] op, input logic use_imm, input logic [31:0] imm);
      in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
      in_op = op; in_use_imm = use_imm; in_imm = imm;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      idle();
      out_ready = 1;
      rst_n = 0;
      step(); step();
      chk("lit_reset_valid", {31'd0, out_valid}, 32'd0);
      chk("lit_reset_illegal", {31'd0, out_illegal}, 32'd0);
      rst_n = 1;
      step();

      // Reset then read: registers are all zero.
      issue(5'd3, 5'd4, 5'd1, 3'b010, 1'b0, 32'd0);
      step(); idle();
      chk("lit_t1_valid", {31'd0, out_valid}, 32'd1);
      chk("lit_t1_a", out_a, 32'd0);
      chk("lit_t1_b", out_b, 32'd0);
      chk("lit_t1_illegal", {31'd0, out_illegal}, 32'd0);

      // Write then read.
      wb_en = 1; wb_addr = 5'd5; wb_data = 32'h0000_00FF;
      step(); idle();
      issue(5'd5, 5'd0, 5'd2, 3'b000, 1'b0, 32'd0);
      step(); idle();
      chk("lit_t2_a", out_a, 32'h0000_00FF);
      chk("lit_t2_b", out_b, 32'd0);

      // Same-cycle bypass with immediate operand b.
      wb_en = 1; wb_addr = 5'd7; wb_data = 32'hDEAD_BEEF;
      issue(5'd7, 5'd0, 5'd3, 3'b010, 1'b1, 32'hFFFF_FFFC);
      step(); idle();
      chk("lit_t3_a", out_a, 32'hDEAD_BEEF);
      chk("lit_t3_b", out_b, 32'hFFFF_FFFC);

      // x0 protection, including a same-cycle write attempt to x0.
      wb_en = 1; wb_addr = 5'd0; wb_data = 32'h1234_5678;
      step(); idle();
      wb_en = 1; wb_addr = 5'd0; wb_data = 32'h1234_5678;
      issue(5'd0, 5'd0, 5'd4, 3'b001, 1'b0, 32'd0);
      step(); idle();
      chk("lit_t4_a", out_a, 32'd0);
      chk("lit_t4_b", out_b, 32'd0);
      step();

      // Backpressure: first instruction held, second waits, no duplicate or loss.
      out_ready = 0;
      issue(5'd5, 5'd7, 5'd8, 3'b001, 1'b0, 32'd0);
      step();
      issue(5'd7, 5'd5, 5'd9, 3'b110, 1'b0, 32'd0);
      step(); step();
      chk("lit_t5_hold_op", {29'd0, out_op}, 32'd1);
      chk("lit_t5_hold_a", out_a, 32'h0000_00FF);
      chk("lit_t5_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1;
      step(); idle();
      chk("lit_t5_second_op", {29'd0, out_op}, 32'd6);
      chk("lit_t5_second_a", out_a, 32'hDEAD_BEEF);
      chk("lit_t5_second_valid", {31'd0, out_valid}, 32'd1);
      step();
      chk("lit_t5_no_dup", {31'd0, out_valid}, 32'd0);

      // Illegal opcode, then flush beating a simultaneous accept; write during flush still lands.
      issue(5'd5, 5'd0, 5'd10, 3'b101, 1'b0, 32'd0);
      step(); idle();
      chk("lit_t6_illegal", {31'd0, out_illegal}, 32'd1);
      chk("lit_t6_op", {29'd0, out_op}, 32'd5);
      flush = 1;
      wb_en = 1; wb_addr = 5'd9; wb_data = 32'hA5A5_0009;
      issue(5'd1, 5'd2, 5'd11, 3'b010, 1'b0, 32'd0);
      step(); idle();
      chk("lit_t6_flushed", {31'd0, out_valid}, 32'd0);
      issue(5'd9, 5'd9, 5'd12, 3'b111, 1'b0, 32'd0);
      step(); idle();
      chk("lit_t6_wb_during_flush", out_a, 32'hA5A5_0009);

      // Mixed burst: writes, reads of just-written registers and toggling backpressure.
      for (int i = 1; i <= 10; i++) begin
         wb_en = 1; wb_addr = 5'(i); wb_data = 32'h0101_0101 * i;
         issue(5'(i - 1), 5'(i), 5'(i), 3'(i), 1'(i % 3 == 0), 32'h8000_0000 | i);
         out_ready = 1'(i % 2);
         step();
      end
      idle();
      out_ready = 1;
      step(); step();

      // Reset mid-operation drops the slot and clears registers.
      out_ready = 0;
      issue(5'd5, 5'd6, 5'd13, 3'b010, 1'b0, 32'd0);
      step(); idle();
      #2 rst_n = 0;
      #1;
      chk("lit_mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("lit_mid_rst_a", out_a, 32'd0);
      step();
      rst_n = 1;
      out_ready = 1;
      issue(5'd5, 5'd6, 5'd14, 3'b000, 1'b0, 32'd0);
      step(); idle();
      chk("lit_after_rst_a", out_a, 32'd0);
      chk("lit_after_rst_b", out_b, 32'd0);
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX stage directly upstream of the 32-bit ALU.
- Holds the architectural register file: 32 x 32 bits, with x0 hardwired to zero.
- Reads two source registers, selects an immediate for operand b when requested, and registers {a, b, op, rd} into one output slot.
- Upstream uses a valid/ready handshake; so does the ALU/EX side. Writeback data is bypassed into operand reads in the same cycle.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, number of registers; the address width is log2(NREG).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept an instruction
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_rd  in  5  destination register
- in_imm  in  XLEN  sign-extended immediate
- in_use_imm  in  1  1 = b takes in_imm; 0 = b takes rs2
- in_op  in  3  ALU opcode
- out_valid  out  1  output slot holds an instruction
- out_ready  in  1  ALU/EX consumes the slot
- out_a  out  XLEN  ALU operand a
- out_b  out  XLEN  ALU operand b
- out_op  out  3  ALU opcode, passed through
- out_rd  out  5  destination register, passed through
- out_illegal  out  1  the op in the slot is not a legal ALU opcode
- wb_en  in  1  register write enable
- wb_addr  in  5  write address
- wb_data  in  XLEN  write data

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0; out_a, out_b, out_op, out_rd and out_illegal all 0.
  - Every register is cleared to 0.
- Legal opcodes: AND=000, OR=001, ADD=010, SUB=110, SLT=111. Opcodes 011, 100, 101 set out_illegal=1; op is still passed through unchanged.
- Ready: in_ready = !out_valid || out_ready. It is a combinational function of state and out_ready only, never of in_valid.
- Capture: on a clock edge where in_valid && in_ready && !flush, the slot loads and out_valid becomes 1. Latency is one cycle from accept to out_valid.
- Drain: if out_valid && out_ready && !(in_valid && in_ready), out_valid drops to 0 at the edge. Accept and drain in the same cycle gives back-to-back throughput of 1 per cycle.
- Stall: while out_valid && !out_ready, all out_* hold stable.
- Flush: at the edge where flush=1, out_valid becomes 0 and no capture occurs, even if in_valid && in_ready. Register file writes still occur. Flush takes priority over accept.
- Operand read at the capture edge:
  - x0 reads as 0.
  - Else, if wb_en && wb_addr==rs, the value is wb_data (same-cycle bypass).
  - Else, the value is the stored register.
  - out_a comes from rs1. out_b comes from in_imm if in_use_imm, else from rs2.
- Write: at the edge where wb_en is high and wb_addr!=0, reg[wb_addr] <= wb_data. Writes to x0 are dropped.
- Writes are independent of the handshake and of flush.
- No hazard interlock against the instruction in the slot. Forwarding from EX is the consumer's responsibility.
- Reset mid-operation drops the in-flight slot and clears the register file.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT;
  - XLEN;
  - REG_AW=5;
  - function alu_op_legal(op).
- Sub-module reg_file_2r1w provides 2 combinational read ports, 1 synchronous write port, x0=0 and asynchronous active-low clear.
- Bypass muxing, the output slot and the handshake logic live in alu_operand_stage.

Test Plan:
- Reset, then read: after reset release, accept rs1=3, rs2=4, op=010, use_imm=0. Response: out_valid=1 next cycle, out_a=0, out_b=0, out_illegal=0.
- Write then read: write x5=0x0000_00FF, then accept rs1=5, rs2=0, op=000. Response: out_a=0x0000_00FF, out_b=0.
- Same-cycle bypass: wb_en=1, wb_addr=7, wb_data=0xDEAD_BEEF in the same cycle as accepting rs1=7, use_imm=1, imm=0xFFFF_FFFC. Response: out_a=0xDEAD_BEEF, out_b=0xFFFF_FFFC.
- x0 protection: write x0=0x1234_5678, then read rs1=0. Response: out_a=0.
- Backpressure: hold out_ready=0 with two instructions offered (op 001, then op 110). Response: the first is held stable and in_ready=0. After out_ready=1 for one cycle, the second appears next cycle with out_op=110; there is no duplicate and no loss.
- Flush and illegal op: accept op=101. Response: out_illegal=1. Then assert flush together with a new in_valid. Response: out_valid=0 next cycle and the new instruction is not captured.
